// File: rtl/cmd_frame_tx_if.sv
// Command-link bundle between a command initiator and its environment.
// Groups the request side (structured command in), the byte stream towards
// the pipeline command input (tx), the response byte from the pipeline
// command output (rx) and the transaction-complete report (done).
//   master : view taken by the initiator (cmd_frame_tx)
//   slave  : view taken by whatever surrounds it (sequencer + pipeline)
interface cmd_frame_tx_if #(
   parameter int MAX_PAYLOAD = 16
);
   localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

   typedef logic [7:0] byte_t;

   logic                     req_valid;
   logic                     req_ready;
   byte_t                    req_opcode;
   logic [LEN_W-1:0]         req_len;
   logic [8*MAX_PAYLOAD-1:0] req_payload;
   logic                     req_expect_resp;

   logic                     tx_valid;
   logic                     tx_ready;
   byte_t                    tx_data;

   logic                     rx_valid;
   logic                     rx_ready;
   byte_t                    rx_data;

   logic                     done_valid;
   logic [1:0]               done_status;
   byte_t                    done_resp;

   modport master (
      input  req_valid, req_opcode, req_len, req_payload, req_expect_resp,
      output req_ready,
      output tx_valid, tx_data,
      input  tx_ready,
      input  rx_valid, rx_data,
      output rx_ready,
      output done_valid, done_status, done_resp
   );

   modport slave (
      output req_valid, req_opcode, req_len, req_payload, req_expect_resp,
      input  req_ready,
      input  tx_valid, tx_data,
      output tx_ready,
      output rx_valid, rx_data,
      input  rx_ready,
      input  done_valid, done_status, done_resp
   );
endinterface

// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx - command-link initiator.
// Accepts one structured command (opcode + up to MAX_PAYLOAD payload bytes),
// serialises it as opcode-first valid/ready bytes, optionally waits for a
// single response byte and reports ok / nack / timeout / none.
// Ports:
//   clk, rst      sole clock, synchronous active-high reset
//   bus           cmd_frame_tx_if.master: req_*, tx_*, rx_*, done_* groups
//   busy          high whenever the controller is not idle
//   stray_count   saturating count of response bytes seen outside the
//                 response window (cleared only by rst)
module cmd_frame_tx #(
   parameter int         MAX_PAYLOAD    = 16,
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [7:0] ACK_VALUE      = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   cmd_frame_tx_if.master        bus,
   output logic                  busy,
   output logic [7:0]            stray_count
);
   localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_NACK = 2'b01;
   localparam logic [1:0] ST_TMO  = 2'b10;
   localparam logic [1:0] ST_NONE = 2'b11;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_OP,
      S_SEND_PAYLOAD,
      S_WAIT_RESP,
      S_DONE
   } state_t;

   state_t                   state;
   logic [8*MAX_PAYLOAD-1:0] payload_q;
   logic [LEN_W-1:0]         len_q;
   logic                     expect_q;
   logic [LEN_W-1:0]         idx;
   logic [CNT_W-1:0]         tmo_cnt;

   logic                     tx_valid_q;
   byte_t                    tx_data_q;
   logic                     done_valid_q;
   logic [1:0]               done_status_q;
   byte_t                    done_resp_q;
   logic                     busy_q;
   logic [7:0]               stray_q;

   logic                     last_byte;
   logic [LEN_W-1:0]         next_idx;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Constant-index mux keeps the byte select free of computed bit offsets.
   function automatic byte_t payload_byte(input logic [8*MAX_PAYLOAD-1:0] pl,
                                          input logic [LEN_W-1:0]         i);
      byte_t b;
      b = '0;
      for (int k = 0; k < MAX_PAYLOAD; k++) begin
         if (i == LEN_W'(k)) b = pl[8*k +: 8];
      end
      return b;
   endfunction

   // The byte currently on tx is the frame's last one when the opcode has
   // no payload behind it, or when the payload index reached len-1.
   always_comb begin
      last_byte = 1'b0;
      next_idx  = '0;
      if (state == S_SEND_OP) begin
         last_byte = (len_q == '0);
         next_idx  = '0;
      end else if (state == S_SEND_PAYLOAD) begin
         last_byte = (idx == len_q - LEN_W'(1));
         next_idx  = idx + LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         tx_valid_q    <= 1'b0;
         tx_data_q     <= '0;
         done_valid_q  <= 1'b0;
         done_status_q <= '0;
         done_resp_q   <= '0;
         busy_q        <= 1'b0;
         stray_q       <= '0;
         idx           <= '0;
         tmo_cnt       <= '0;
      end else begin
         done_valid_q <= 1'b0;

         // rx_ready is always high out of reset, so any rx_valid outside the
         // response window is a discarded stray byte.
         if (bus.rx_valid && (state != S_WAIT_RESP)) stray_q <= sat_inc(stray_q);

         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  payload_q  <= bus.req_payload;
                  len_q      <= clamp_len(bus.req_len);
                  expect_q   <= bus.req_expect_resp;
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= bus.req_opcode;
                  busy_q     <= 1'b1;
                  state      <= S_SEND_OP;
               end
            end

            S_SEND_OP, S_SEND_PAYLOAD: begin
               if (bus.tx_ready) begin
                  if (last_byte) begin
                     tx_valid_q <= 1'b0;
                     if (expect_q) begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT_RESP;
                     end else begin
                        done_valid_q  <= 1'b1;
                        done_status_q <= ST_NONE;
                        done_resp_q   <= '0;
                        state         <= S_DONE;
                     end
                  end else begin
                     idx       <= next_idx;
                     tx_data_q <= payload_byte(payload_q, next_idx);
                     state     <= S_SEND_PAYLOAD;
                  end
               end
            end

            S_WAIT_RESP: begin
               // A byte arriving on the final counted cycle still wins over timeout.
               if (bus.rx_valid) begin
                  done_valid_q  <= 1'b1;
                  done_resp_q   <= bus.rx_data;
                  done_status_q <= (bus.rx_data == ACK_VALUE) ? ST_OK : ST_NACK;
                  state         <= S_DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  done_valid_q  <= 1'b1;
                  done_resp_q   <= '0;
                  done_status_q <= ST_TMO;
                  state         <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               tx_valid_q <= 1'b0;
               busy_q     <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

   // Both ready outputs are forced low for the whole time rst is high,
   // including the cycle before the reset edge takes effect.
   assign bus.req_ready   = (state == S_IDLE) && !rst;
   assign bus.rx_ready    = !rst;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.done_valid  = done_valid_q;
   assign bus.done_status = done_status_q;
   assign bus.done_resp   = done_resp_q;
   assign busy            = busy_q;
   assign stray_count     = stray_q;

endmodule
